dial_zero_counter: RTL
======================

Name: dial_zero_counter

Overview:
- Parametrised circular-dial tracker for the puzzle-solution datapath.
- Consumes rotation packets (direction + distance) over a valid/ready handshake and tracks the dial position modulo DIAL_SIZE.
- Accumulates a zero count in one of two run-time modes: landings on zero, or every click through zero.
- Uses an iterative restoring divider, so distances of any VAL_W-bit size are handled exactly without a combinational divide.

Parameters:
- DIAL_SIZE, 100: number of dial positions. Requires 2 <= DIAL_SIZE < 2^VAL_W.
- INIT_POS, 50: position after reset. Requires INIT_POS < DIAL_SIZE.
- VAL_W, 31: distance field width.
- CNT_W, 32: answer counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high. Clock is clk.
- i_valid  in  1  packet valid
- o_ready  out  1  block can accept a packet
- i_packet  in  VAL_W+1  bit VAL_W = direction (1 = right/increment, 0 = left/decrement); bits VAL_W-1:0 = distance d (unsigned)
- i_mode  in  1  0 = count landings on 0; 1 = count every click that reaches 0
- i_last  in  1  marks final packet of a sequence
- o_position  out  clog2(DIAL_SIZE)  current dial position
- o_answer  out  CNT_W  accumulated zero count
- o_done  out  1  one-cycle pulse when the i_last packet commits

Behaviour:
- Reset values:
  - o_position = INIT_POS, o_answer = 0, o_done = 0, o_ready = 1.
  - FSM returns to IDLE.
  - Reset mid-operation aborts the in-flight packet with no commit.
- Handshake:
  - A packet is accepted on a cycle T where i_valid && o_ready.
  - i_packet, i_mode and i_last are latched at acceptance.
  - Input changes after acceptance have no effect.
  - o_ready = 1 only in IDLE.
- FSM states:
  - IDLE: on accept, go to DIV.
  - DIV: exactly VAL_W cycles of restoring division, producing q = d / DIAL_SIZE and r = d % DIAL_SIZE. Then go to COMMIT.
  - COMMIT: one cycle. Registers update at the end of this cycle, then go to IDLE.
- Timing:
  - New o_position and o_answer are visible from cycle T+VAL_W+2.
  - o_ready is high again in cycle T+VAL_W+2.
  - Maximum throughput is one packet per VAL_W+2 cycles.
- Update rules (p = old position):
  - Right: p' = p + r, minus DIAL_SIZE if p + r >= DIAL_SIZE. clicks = q + (p + r >= DIAL_SIZE ? 1 : 0).
  - Left: p' = p - r, plus DIAL_SIZE if r > p. clicks = q + ((p != 0 && r >= p) ? 1 : 0).
  - Mode 0: o_answer += (p' == 0).
  - Mode 1: o_answer += clicks.
- Boundary cases:
  - d = 0: position unchanged. Mode 1 adds 0. Mode 0 adds 1 if p == 0.
  - Starting at 0 and moving left does not count the departure.
  - d an exact multiple of DIAL_SIZE: p' = p and clicks = q, in either direction.
  - Maximum distance (all ones) must give exact q and r. Intermediate sums are at least clog2(DIAL_SIZE)+1 bits wide, so they never overflow.
- o_answer overflow: wraps modulo 2^CNT_W (see optional feature).
- o_done is asserted only in the COMMIT cycle of an i_last packet. It is otherwise 0.

Optional Feature:
- DIAL_ZERO_COUNTER_SAT_EN defined:
  - The o_answer addition saturates at 2^CNT_W-1.
  - Adds output port o_sat (1 bit, reset 0), which is sticky-high once saturation occurs and is cleared only by rst.
- Not defined: o_answer wraps modulo 2^CNT_W and the o_sat port is absent.

Test Plan:
- Example sequence, mode 1, defaults (L68, L30, R48, L5, R60, L55, L1, L99, R14, L82 fed back-to-back, i_valid held high) -> o_answer = 6, final o_position = 32, o_done pulses once after the L82 commit.
- Same sequence, mode 0 -> o_answer = 3, o_position = 32.
- Reset state, R1000 in mode 1 -> o_answer = 10, o_position = 50. Latency check: o_ready low for cycles T+1 through T+32, and the update is visible from T+33 (VAL_W = 31).
- Position 0 (after L50), then L5 in mode 1 -> answer unchanged, position 95. Then R5 -> answer +1, position 0. Then R0 in mode 0 -> answer +1.
- Assert rst during DIV of R250 -> position 50, answer 0, o_ready = 1 next cycle, no o_done. An immediately following packet is processed normally.
- CNT_W = 4, mode 1, R2000 -> wraps to 4. With DIAL_ZERO_COUNTER_SAT_EN: o_answer = 15, o_sat = 1.

Source files
------------

// File: rtl/dial_zero_counter.sv
// Circular dial tracker: an iterative restoring divider splits each distance into laps and remainder,
// then one commit cycle updates position and zero count. DIAL_ZERO_COUNTER_SAT_EN: saturating answer + o_sat.
module dial_zero_counter #(
  parameter int DIAL_SIZE = 100,
  parameter int INIT_POS  = 50,
  parameter int VAL_W     = 31,
  parameter int CNT_W     = 32,
  localparam int PW       = $clog2(DIAL_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [VAL_W:0]   i_packet,
  input  logic             i_mode,
  input  logic             i_last,
  output logic [PW-1:0]    o_position,
  output logic [CNT_W-1:0] o_answer,
`ifdef DIAL_ZERO_COUNTER_SAT_EN
  output logic             o_sat,
`endif
  output logic             o_done
);
  localparam int SW = PW + 1;
  localparam int CW = $clog2(VAL_W + 1);
  localparam int AW = ((CNT_W > VAL_W) ? CNT_W : VAL_W) + 1;
  localparam logic [SW-1:0] DS   = SW'(DIAL_SIZE);
  localparam logic [PW-1:0] INIT = PW'(INIT_POS);

  typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;
  state_t state, state_nx;

  logic [CW-1:0]    step;
  logic [VAL_W-1:0] quo;   // dividend shifts out, quotient shifts in
  logic [PW-1:0]    rem;
  logic             dir, mode, last, accept;

  logic [SW-1:0] part, p_ext, r_ext, sum_r;
  logic          ge, wrap_r, wrap_l, hit;
  logic [PW-1:0] pos_nx;
  logic [AW-1:0] incr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_done   = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept   = 1'b1;
          state_nx = DIV;
        end
      end
      DIV:     if (step == CW'(VAL_W - 1)) state_nx = COMMIT;
      COMMIT: begin
        o_done   = last;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Partial remainder never reaches DIAL_SIZE, so PW+1 bits hold the trial value.
  assign part = {rem, quo[VAL_W-1]};
  assign ge   = (part >= DS);

  assign p_ext  = {1'b0, o_position};
  assign r_ext  = {1'b0, rem};
  assign sum_r  = p_ext + r_ext;
  assign wrap_r = (sum_r >= DS);
  assign wrap_l = (r_ext > p_ext);

  always_comb begin
    if (dir) begin
      pos_nx = PW'(wrap_r ? sum_r - DS : sum_r);
      hit    = wrap_r;
    end else begin
      pos_nx = PW'(wrap_l ? p_ext + DS - r_ext : p_ext - r_ext);
      hit    = (o_position != '0) && (rem >= o_position);
    end
    incr = mode ? (AW'(quo) + AW'(hit)) : AW'(pos_nx == '0);
  end

`ifdef DIAL_ZERO_COUNTER_SAT_EN
  localparam logic [AW-1:0] MAXV = AW'({CNT_W{1'b1}});
  logic [AW-1:0] total;
  logic          sat_hit;
  assign total   = AW'(o_answer) + incr;
  assign sat_hit = (total > MAXV);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o_position <= INIT;
      o_answer   <= '0;
      quo        <= '0;
      rem        <= '0;
      step       <= '0;
      dir        <= 1'b0;
      mode       <= 1'b0;
      last       <= 1'b0;
`ifdef DIAL_ZERO_COUNTER_SAT_EN
      o_sat      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          quo  <= i_packet[VAL_W-1:0];
          dir  <= i_packet[VAL_W];
          mode <= i_mode;
          last <= i_last;
          rem  <= '0;
          step <= '0;
        end
        DIV: begin
          quo  <= {quo[VAL_W-2:0], ge};
          rem  <= PW'(ge ? part - DS : part);
          step <= step + CW'(1);
        end
        COMMIT: begin
          o_position <= pos_nx;
`ifdef DIAL_ZERO_COUNTER_SAT_EN
          o_answer   <= sat_hit ? '1 : CNT_W'(total);
          if (sat_hit) o_sat <= 1'b1;
`else
          o_answer   <= CNT_W'(AW'(o_answer) + incr);
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
